// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mul_issue_ctrl
// Brief   : RV32M multiply issue/control stage in front of a start/done
//           multiplier; zero-operand bypass, result half select, flush.
// Revision: 1.0  initial release
// ============================================================================
module mul_issue_ctrl #(
    parameter int OPERAND_WIDTH = 32,
    parameter int TAG_WIDTH     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       br_mispredict,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_funct3,
    input  logic [OPERAND_WIDTH-1:0]   in_rs1,
    input  logic [OPERAND_WIDTH-1:0]   in_rs2,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       mul_start,
    output logic [1:0]                 mul_type,
    output logic [OPERAND_WIDTH-1:0]   mul_a,
    output logic [OPERAND_WIDTH-1:0]   mul_b,
    input  logic [2*OPERAND_WIDTH-1:0] mul_p,
    input  logic                       mul_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPERAND_WIDTH-1:0]   out_result,
    output logic [TAG_WIDTH-1:0]       out_tag
);

    localparam int OW = OPERAND_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_hi;
    logic [1:0]            r_mul_type;
    logic [OW-1:0]         r_mul_a;
    logic [OW-1:0]         r_mul_b;
    logic [OW-1:0]         r_result;
    logic [TAG_WIDTH-1:0]  r_tag;

    logic                  w_accept;
    logic                  w_bypass;
    logic                  w_capture;
    logic                  w_hi;
    logic [1:0]            w_type;

    // funct3[1:0]: 00 MUL(low,uu) 01 MULH(ss) 10 MULHSU(su) 11 MULHU(uu)
    always_comb begin
        w_type = 2'b00;
        w_hi   = 1'b1;
        case (in_funct3[1:0])
            2'b00:   w_hi   = 1'b0;
            2'b01:   w_type = 2'b01;
            2'b10:   w_type = 2'b10;
            default: w_type = 2'b00;
        endcase
    end

    assign w_bypass  = in_funct3[2] || (in_rs1 == '0) || (in_rs2 == '0);
    assign in_ready  = (r_state == S_IDLE) && rst_n && !br_mispredict;
    assign w_accept  = in_valid && in_ready;
    assign w_capture = (r_state == S_BUSY) && mul_done && !br_mispredict;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_bypass ? S_RESP : S_BUSY;
            S_BUSY: if (mul_done) w_next = S_RESP;
            S_RESP: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (br_mispredict) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hi       <= 1'b0;
            r_mul_type <= 2'b00;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_result   <= '0;
            r_tag      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mul_type <= w_type;
                r_mul_a    <= in_rs1;
                r_mul_b    <= in_rs2;
                r_tag      <= in_tag;
                r_hi       <= w_hi;
                // Bypassed ops answer 0; multiplied ops overwrite this on done.
                r_result   <= '0;
            end else if (w_capture) begin
                r_result <= r_hi ? mul_p[2*OW-1:OW] : mul_p[OW-1:0];
            end
        end
    end

    assign mul_start  = (r_state == S_BUSY);
    assign out_valid  = (r_state == S_RESP);
    assign mul_type   = r_mul_type;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign out_result = r_result;
    assign out_tag    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_issue_ctrl
// Brief   : Self-checking bench for mul_issue_ctrl with a behavioural
//           start/done multiplier and an arithmetic reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_mul_issue_ctrl;

    localparam int OW  = 32;
    localparam int TW  = 5;
    localparam int LAT = 34;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          br_mispredict = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_funct3 = 3'b000;
    logic [OW-1:0] in_rs1 = '0;
    logic [OW-1:0] in_rs2 = '0;
    logic [TW-1:0] in_tag = '0;
    logic          mul_start;
    logic [1:0]    mul_type;
    logic [OW-1:0] mul_a;
    logic [OW-1:0] mul_b;
    logic [2*OW-1:0] mul_p;
    logic          mul_done;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_result;
    logic [TW-1:0] out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.OPERAND_WIDTH(OW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .br_mispredict(br_mispredict),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .mul_start(mul_start), .mul_type(mul_type), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p(mul_p), .mul_done(mul_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    // Behavioural multi-cycle multiplier: done after LAT cycles of start,
    // held until start drops; product is X whenever done is low.
    int            m_cnt;
    logic          m_done;
    logic [2*OW-1:0] m_prod;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (!mul_start) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (!m_done) begin
            if (m_cnt == LAT - 1) begin
                m_done <= 1'b1;
                m_prod <= ext_mul(mul_a, mul_b, mul_type);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end
    assign mul_done = m_done;
    assign mul_p    = m_done ? m_prod : 'x;

    function automatic logic [2*OW-1:0] ext_mul(input logic [OW-1:0] a,
                                                input logic [OW-1:0] b,
                                                input logic [1:0] t);
        logic [2*OW-1:0] ae, be;
        ae = (t != 2'b00) ? {{OW{a[OW-1]}}, a} : {{OW{1'b0}}, a};
        be = (t == 2'b01) ? {{OW{b[OW-1]}}, b} : {{OW{1'b0}}, b};
        return ae * be;
    endfunction

    // Reference: RV32M result semantics straight from funct3.
    function automatic logic [OW-1:0] ref_result(input logic [2:0] f3,
                                                 input logic [OW-1:0] a,
                                                 input logic [OW-1:0] b);
        longint signed sa, sb;
        longint unsigned ua, ub;
        logic [127:0] p;
        if (f3[2]) return '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3[1:0])
            2'b00:   p = {64'b0, ua * ub};
            2'b01:   p = {64'b0, sa * sb};
            2'b10:   p = {64'b0, sa * longint'(ub)};
            default: p = {64'b0, ua * ub};
        endcase
        return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Issue one op, wait for its result, hold out_ready low for hold cycles, retire.
    task automatic do_op(input string name, input logic [2:0] f3, input logic [OW-1:0] a,
                         input logic [OW-1:0] b, input logic [TW-1:0] tag, input int hold);
        logic bypass, prev_done, seen_start, got;
        logic [OW-1:0] exp;
        int cyc;
        exp    = ref_result(f3, a, b);
        bypass = (a == 0) || (b == 0) || f3[2];
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_tag = tag;
        chk({name, ".in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0; prev_done = 1'b0; seen_start = 1'b0; got = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({name, ".start_1st"}, 64'(mul_start), 64'(!bypass));
            if (out_valid) begin got = 1'b1; break; end
            if (mul_start) seen_start = 1'b1;
            prev_done = mul_done;
        end
        chk({name, ".got_result"}, 64'(got), 64'(1));
        if (bypass) chk({name, ".bypass_lat"}, 64'(cyc), 64'(1));
        else begin
            chk({name, ".done_then_valid"}, 64'(prev_done), 64'(1));
            chk({name, ".seen_start"}, 64'(seen_start), 64'(1));
        end
        chk({name, ".result"}, 64'(out_result), 64'(exp));
        chk({name, ".tag"}, 64'(out_tag), 64'(tag));
        chk({name, ".start_in_resp"}, 64'(mul_start), 64'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, ".hold"}, {out_valid, in_ready, out_tag, out_result},
                {1'b1, 1'b0, tag, exp});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, ".retired"}, {out_valid, in_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst.ctrl", {in_ready, mul_start, out_valid}, 0);
        chk("rst.data", {mul_type, mul_a, mul_b, out_result, out_tag}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready_after", 64'(in_ready), 64'(1));

        // Basic MUL and the four RV32M flavours on (-2, 3)
        do_op("mul7x6", 3'b000, 32'd7, 32'd6, 5'd3, 0);
        chk("mul7x6.abs", 64'(ref_result(3'b000, 32'd7, 32'd6)), 64'd42);
        do_op("mulh", 3'b001, 32'hFFFFFFFE, 32'd3, 5'd1, 0);
        do_op("mulhu", 3'b011, 32'hFFFFFFFE, 32'd3, 5'd2, 0);
        do_op("mulhsu", 3'b010, 32'hFFFFFFFE, 32'd3, 5'd4, 0);
        do_op("mul_neg", 3'b000, 32'hFFFFFFFE, 32'd3, 5'd5, 0);
        chk("mul_types", mul_type, 2'b00);

        // Zero-operand and illegal-funct3 bypass
        do_op("bypass_zero", 3'b011, 32'h1234_5678, 32'd0, 5'd9, 0);
        do_op("illegal", 3'b101, 32'd9, 32'd9, 5'd10, 0);

        // Consumer backpressure
        do_op("backpressure", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd17, 5);

        // Flush mid-multiply, with a concurrent in_valid
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd11; in_rs2 = 32'd13; in_tag = 5'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush.busy", 64'(mul_start), 64'(1));
        br_mispredict = 1'b1;
        in_valid = 1'b1;
        #1 chk("flush.ready_low", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        br_mispredict = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush.idle", {mul_start, out_valid, in_ready}, {1'b0, 1'b0, 1'b1});
        begin
            logic any_valid;
            any_valid = 1'b0;
            for (int i = 0; i < LAT + 6; i++) begin
                @(negedge clk);
                if (out_valid || mul_start) any_valid = 1'b1;
            end
            chk("flush.quiet", 64'(any_valid), 64'(0));
        end
        do_op("after_flush", 3'b000, 32'd5, 32'd5, 5'd12, 0);

        // Asynchronous reset mid-multiply
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd9; in_rs2 = 32'd9; in_tag = 5'd21;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("areset.outs", {in_ready, mul_start, out_valid, mul_type, mul_a, mul_b,
                               out_result, out_tag}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_reset", 3'b000, 32'd3, 32'd4, 5'd6, 0);

        // Randomised ops against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [2:0]    f3;
            logic [OW-1:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            do_op("rand", f3, a, b, 5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
